// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/decode slice: state encoding, instruction fields,
// opcode constants and the default program image.
package fetch_pkg;

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StIssue, StHalted} state_t;

    localparam int unsigned InstrW  = 12;
    localparam int unsigned CtrlBit = 11;
    localparam int unsigned OpHi    = 10;
    localparam int unsigned OpLo    = 8;
    localparam int unsigned ImmHi   = 7;
    localparam int unsigned ImmLo   = 0;

    localparam logic [2:0] CtrlJmp  = 3'b000;
    localparam logic [2:0] CtrlHalt = 3'b001;

    localparam logic [2:0] RfLoad0 = 3'b000;
    localparam logic [2:0] RfLoad1 = 3'b001;
    localparam logic [2:0] RfMov10 = 3'b010;  // R1 <- R0
    localparam logic [2:0] RfMov01 = 3'b011;  // R0 <- R1
    localparam logic [2:0] RfOut0  = 3'b100;
    localparam logic [2:0] RfOut1  = 3'b101;
    localparam logic [2:0] RfNop   = 3'b111;

    typedef logic [InstrW-1:0] instr_t;

    function automatic instr_t mk_data(input logic [2:0] op, input logic [7:0] imm);
        return {1'b0, op, imm};
    endfunction

    function automatic instr_t mk_ctrl(input logic [2:0] op, input logic [7:0] imm);
        return {1'b1, op, imm};
    endfunction

    function automatic instr_t default_word(input int unsigned addr);
        case (addr)
            0:       return mk_data(RfLoad0, 8'h5A);
            1:       return mk_data(RfMov10, 8'h00);
            2:       return mk_data(RfOut1, 8'h00);
            default: return mk_ctrl(CtrlHalt, 8'h00);
        endcase
    endfunction

endpackage

// File: rtl/fetch_rom.sv
// Instruction store with a registered read port. Writable only when FETCH_PROG_LOAD_EN
// is defined; otherwise a constant image from fetch_pkg.
module fetch_rom
    import fetch_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 16,
    parameter int unsigned IW        = 12,
    parameter int unsigned AW        = $clog2(ROM_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
`ifdef FETCH_PROG_LOAD_EN
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
`endif
    output logic [IW-1:0] rd_data
);

    logic [IW-1:0] rom_word;

`ifdef FETCH_PROG_LOAD_EN
    logic [ROM_DEPTH-1:0][IW-1:0] mem;

    // Storage powers up holding the default image and is never touched by reset.
    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_word
        logic [IW-1:0] word_q = IW'(default_word(i));

        always_ff @(posedge clock) begin
            if (wr_en && wr_addr == AW'(i)) begin
                word_q <= wr_data;
            end
        end

        assign mem[i] = word_q;
    end

    always_comb rom_word = mem[rd_addr];
`else
    always_comb rom_word = IW'(default_word(32'(rd_addr)));
`endif

    // The read register doubles as the instruction register, so it does reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rom_word;
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode/issue sequencer feeding a register file from fetch_rom.
// Define FETCH_PROG_LOAD_EN to add the prog_we/prog_addr/prog_data load port.
module fetch_decode
    import fetch_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 16,
    parameter int unsigned IW        = 12
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ena,
    input  logic                         run,
    input  logic                         hold,
`ifdef FETCH_PROG_LOAD_EN
    input  logic                         prog_we,
    input  logic [$clog2(ROM_DEPTH)-1:0] prog_addr,
    input  logic [IW-1:0]                prog_data,
`endif
    output logic [2:0]                   reg_opcode,
    output logic [7:0]                   reg_data,
    output logic                         reg_ena,
    output logic [$clog2(ROM_DEPTH)-1:0] pc,
    output logic                         halted
);

    localparam int unsigned PW = $clog2(ROM_DEPTH);

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d, pc_inc;
    logic [2:0]    opcode_q, opcode_d;
    logic [7:0]    data_q, data_d;
    logic [IW-1:0] ir;
    logic          fetch_en;

    fetch_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .IW        (IW),
        .AW        (PW)
    ) u_rom (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (fetch_en),
        .rd_addr (pc_q),
`ifdef FETCH_PROG_LOAD_EN
        .wr_en   (prog_we && ena && (state_q == StIdle || state_q == StHalted)),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
`endif
        .rd_data (ir)
    );

    assign pc_inc = (pc_q == PW'(ROM_DEPTH - 1)) ? '0 : pc_q + PW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            opcode_q <= RfNop;
            data_q   <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (run) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (ir[CtrlBit]) begin
                    case (ir[OpHi:OpLo])
                        CtrlJmp: begin
                            pc_d    = ir[ImmLo +: PW];
                            state_d = StFetch;
                        end
                        CtrlHalt: state_d = StHalted;
                        default: begin
                            pc_d    = pc_inc;
                            state_d = StFetch;
                        end
                    endcase
                end else begin
                    opcode_d = ir[OpHi:OpLo];
                    data_d   = ir[ImmHi:ImmLo];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (!hold) begin
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fetch_en = (state_q == StFetch) && ena;
        reg_ena  = (state_q == StIssue) && !hold && ena;
        halted   = (state_q == StHalted);
    end

    assign pc         = pc_q;
    assign reg_opcode = opcode_q;
    assign reg_data   = data_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: cycle table for the default program plus
// hand-written hold, reset and (with FETCH_PROG_LOAD_EN) program-load sequences.
module tb_fetch_decode;
    import fetch_pkg::*;

    logic       clock = 1'b0;
    logic       reset, ena, run, hold;
    logic [2:0] reg_opcode;
    logic [7:0] reg_data;
    logic       reg_ena;
    logic [3:0] pc;
    logic       halted;
`ifdef FETCH_PROG_LOAD_EN
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_data = '0;
`endif

    always #5 clock = ~clock;

    fetch_decode #(
        .ROM_DEPTH (16),
        .IW        (12)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ena        (ena),
        .run        (run),
        .hold       (hold),
`ifdef FETCH_PROG_LOAD_EN
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
`endif
        .reg_opcode (reg_opcode),
        .reg_data   (reg_data),
        .reg_ena    (reg_ena),
        .pc         (pc),
        .halted     (halted)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       chk_data;
    } exp_t;

    typedef struct {
        logic       run, ena, hold;
        logic [3:0] pc;
        logic       halted, rena;
        logic [2:0] op;
        logic [7:0] data;
    } vec_t;

    exp_t sb[$];
    int   strobe_cyc[$];
    int   strobe_cnt = 0;
    int   cyc = 0;
    logic prev_ena = 1'b0;
    exp_t mon_e;

    function automatic exp_t mk_exp(input logic [2:0] op, input logic [7:0] d, input logic c);
        exp_t e;
        e.op = op; e.data = d; e.chk_data = c;
        return e;
    endfunction

    function automatic vec_t v(input logic r, input logic e, input logic h, input int p,
                               input logic hl, input logic re, input int op, input int d);
        vec_t x;
        x.run = r; x.ena = e; x.hold = h; x.pc = 4'(p); x.halted = hl; x.rena = re;
        x.op = 3'(op); x.data = 8'(d);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    // Strobe monitor: every reg_ena pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            prev_ena = 1'b0;
        end else begin
            if (reg_ena) begin
                strobe_cnt++;
                strobe_cyc.push_back(cyc);
                check("no back-to-back strobe", 32'(prev_ena), 32'(0));
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected strobe: op=%0h data=%0h, expected no strobe",
                             reg_opcode, reg_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe opcode", 32'(reg_opcode), 32'(mon_e.op));
                    if (mon_e.chk_data) check("strobe data", 32'(reg_data), 32'(mon_e.data));
                end
            end
            prev_ena = reg_ena;
        end
    end

    task automatic push_default();
        sb.push_back(mk_exp(RfLoad0, 8'h5A, 1'b1));
        sb.push_back(mk_exp(RfMov10, 8'h00, 1'b0));
        sb.push_back(mk_exp(RfOut1, 8'h00, 1'b0));
    endtask

    task automatic start_run();
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_halted(input int budget, input string name);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(halted), 32'(1));
        @(posedge clock);
        #1;
    endtask

`ifdef FETCH_PROG_LOAD_EN
    task automatic load(input int a, input logic [11:0] d);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        @(posedge clock);
        #1;
        prog_we = 1'b0;
    endtask
`endif

    vec_t vt[15];

    initial begin
        int s0;
        int n;

        // run / ena / hold / pc / halted / reg_ena / opcode / data
        vt[0]  = v(1, 1, 0, 0, 0, 0, 7, 'h00);
        vt[1]  = v(0, 0, 0, 0, 0, 0, 7, 'h00);  // FETCH frozen by ena
        vt[2]  = v(0, 1, 0, 0, 0, 0, 7, 'h00);
        vt[3]  = v(0, 1, 0, 0, 0, 0, 7, 'h00);
        vt[4]  = v(0, 1, 0, 0, 0, 1, 0, 'h5A);
        vt[5]  = v(1, 1, 0, 1, 0, 0, 0, 'h5A);  // run ignored mid-program
        vt[6]  = v(0, 1, 0, 1, 0, 0, 0, 'h5A);
        vt[7]  = v(0, 1, 0, 1, 0, 1, 2, 'h00);
        vt[8]  = v(0, 1, 0, 2, 0, 0, 2, 'h00);
        vt[9]  = v(0, 1, 0, 2, 0, 0, 2, 'h00);
        vt[10] = v(0, 1, 0, 2, 0, 1, 5, 'h00);
        vt[11] = v(0, 1, 0, 3, 0, 0, 5, 'h00);
        vt[12] = v(0, 1, 0, 3, 0, 0, 5, 'h00);
        vt[13] = v(1, 0, 0, 3, 1, 0, 5, 'h00);  // HALTED ignores run while ena=0
        vt[14] = v(0, 1, 0, 3, 1, 0, 5, 'h00);

        reset = 1'b1; ena = 1'b1; run = 1'b0; hold = 1'b0;
        @(negedge clock);
        check("reset pc", 32'(pc), 32'(0));
        check("reset opcode", 32'(reg_opcode), 32'(3'b111));
        check("reset data", 32'(reg_data), 32'(0));
        check("reset reg_ena", 32'(reg_ena), 32'(0));
        check("reset halted", 32'(halted), 32'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        push_default();
        for (int i = 0; i < 15; i++) begin
            run = vt[i].run; ena = vt[i].ena; hold = vt[i].hold;
            @(negedge clock);
            check($sformatf("row%0d pc", i), 32'(pc), 32'(vt[i].pc));
            check($sformatf("row%0d halted", i), 32'(halted), 32'(vt[i].halted));
            check($sformatf("row%0d reg_ena", i), 32'(reg_ena), 32'(vt[i].rena));
            check($sformatf("row%0d opcode", i), 32'(reg_opcode), 32'(vt[i].op));
            check($sformatf("row%0d data", i), 32'(reg_data), 32'(vt[i].data));
            @(posedge clock);
            #1;
        end
        run = 1'b0; ena = 1'b1;
        check("default run scoreboard drained", 32'(sb.size()), 32'(0));
        check("default run strobe count", 32'(strobe_cyc.size()), 32'(3));
        if (strobe_cyc.size() == 3) begin
            check("strobe spacing 1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(3));
            check("strobe spacing 2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'(3));
        end

        // Hold for 5 cycles in the first ISSUE after restarting from HALTED.
        push_default();
        start_run();
        hold = 1'b1;
        @(negedge clock);
        check("restart pc", 32'(pc), 32'(0));
        check("restart halted", 32'(halted), 32'(0));
        @(posedge clock); #1;
        @(posedge clock); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("hold%0d reg_ena", k), 32'(reg_ena), 32'(0));
            check($sformatf("hold%0d opcode", k), 32'(reg_opcode), 32'(RfLoad0));
            check($sformatf("hold%0d data", k), 32'(reg_data), 32'(8'h5A));
            @(posedge clock); #1;
        end
        hold = 1'b0;
        @(negedge clock);
        check("strobe after hold", 32'(reg_ena), 32'(1));
        @(posedge clock); #1;
        @(negedge clock);
        check("single strobe after hold", 32'(reg_ena), 32'(0));
        wait_halted(40, "halt after hold run");
        check("hold run scoreboard drained", 32'(sb.size()), 32'(0));

        // Reset asserted in the middle of the second ISSUE.
        start_run();
        sb.push_back(mk_exp(RfLoad0, 8'h5A, 1'b1));
        repeat (4) @(posedge clock);
        #1;
        hold = 1'b1;
        @(posedge clock);
        #2;
        check("pre-reset pc", 32'(pc), 32'(1));
        check("pre-reset opcode", 32'(reg_opcode), 32'(RfMov10));
        reset = 1'b1;
        #1;
        check("mid-issue reset pc", 32'(pc), 32'(0));
        check("mid-issue reset opcode", 32'(reg_opcode), 32'(3'b111));
        check("mid-issue reset data", 32'(reg_data), 32'(0));
        check("mid-issue reset reg_ena", 32'(reg_ena), 32'(0));
        check("mid-issue reset halted", 32'(halted), 32'(0));
        check("scoreboard before reset", 32'(sb.size()), 32'(0));
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        hold  = 1'b0;
        s0 = strobe_cnt;
        repeat (10) @(posedge clock);
        #1;
        check("no strobe after reset", 32'(strobe_cnt - s0), 32'(0));
        check("idle pc after reset", 32'(pc), 32'(0));
        push_default();
        start_run();
        wait_halted(40, "halt after reset rerun");
        check("rerun scoreboard drained", 32'(sb.size()), 32'(0));

`ifdef FETCH_PROG_LOAD_EN
        // JMP at 3 -> 15, JMP at 15 -> 2.
        load(3, mk_ctrl(CtrlJmp, 8'h0F));
        load(15, mk_ctrl(CtrlJmp, 8'h02));
        push_default();
        start_run();
        n = 0;
        while (pc != 4'd15 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("reach pc 15", 32'(pc), 32'(15));
        s0 = strobe_cnt;
        n = 0;
        while (pc == 4'd15 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("pc after JMP at 15", 32'(pc), 32'(2));
        check("no strobe for JMP", 32'(strobe_cnt - s0), 32'(0));
        check("jmp run scoreboard drained", 32'(sb.size()), 32'(0));
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;

        // Fill with LOAD0 imm=addr, no HALT: pc wraps 15 -> 0.
        for (int a = 0; a < 16; a++) load(a, mk_data(RfLoad0, 8'(a)));
        for (int a = 0; a < 18; a++) sb.push_back(mk_exp(RfLoad0, 8'(a % 16), 1'b1));
        s0 = strobe_cnt;
        start_run();
        n = 0;
        while (strobe_cnt - s0 < 18 && n < 80) begin
            @(negedge clock);
            n++;
        end
        check("wrap strobe count", 32'(strobe_cnt - s0), 32'(18));
        check("wrap scoreboard drained", 32'(sb.size()), 32'(0));
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;

        // Write while running is dropped; write while HALTED takes effect.
        load(1, mk_ctrl(CtrlHalt, 8'h00));
        sb.push_back(mk_exp(RfLoad0, 8'h00, 1'b1));
        start_run();
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = mk_data(RfLoad1, 8'h33);
        repeat (3) @(posedge clock);
        #1;
        prog_we = 1'b0;
        wait_halted(20, "halt after dropped write");
        sb.push_back(mk_exp(RfLoad0, 8'h00, 1'b1));
        start_run();
        wait_halted(20, "halt after dropped-write check");
        load(0, mk_data(RfLoad1, 8'h33));
        sb.push_back(mk_exp(RfLoad1, 8'h33, 1'b1));
        start_run();
        wait_halted(20, "halt after halted write");
        check("load scoreboard drained", 32'(sb.size()), 32'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 16, meaning the number of instruction words; PC width is log2(ROM_DEPTH).
REQ-002 SHALL have parameter IW, default 12, meaning the instruction width: [11] ctrl flag, [10:8] op, [7:0] imm.
REQ-003 SHALL have port clock  input  1  the single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ena  input  1  global enable; when low, all state freezes.
REQ-006 SHALL have port run  input  1  start request, level-sampled.
REQ-007 SHALL have port hold  input  1  downstream stall request.
REQ-008 SHALL have port reg_opcode  output  3  register-file opcode.
REQ-009 SHALL have port reg_data  output  8  immediate data for the register file.
REQ-010 SHALL have port reg_ena  output  1  one-cycle issue strobe to the register file.
REQ-011 SHALL have port pc  output  log2(ROM_DEPTH)  current program counter.
REQ-012 SHALL have port halted  output  1  high while in the HALTED state.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, ISSUE, HALTED, with every transition gated by ena=1.
REQ-014 SHALL transition IDLE->FETCH when run=1, with pc=0.
REQ-015 SHALL, in FETCH, latch rom[pc] into the instruction register and go to DECODE.
REQ-016 SHALL, in DECODE, handle each instruction class:
- ctrl=1, op=000 (JMP): pc <= imm[log2(ROM_DEPTH)-1:0], go to FETCH.
- ctrl=1, op=001 (HALT): go to HALTED.
- ctrl=1, any other op: treat as NOP; pc <= pc+1, go to FETCH.
- ctrl=0: register reg_opcode <= op and reg_data <= imm, go to ISSUE.
REQ-017 SHALL, in ISSUE with hold=1, remain in ISSUE with reg_ena=0 and reg_opcode/reg_data stable.
REQ-018 SHALL, in ISSUE with hold=0, drive reg_ena=1 combinationally (state==ISSUE && !hold && ena), increment pc, and go to FETCH.
REQ-019 SHALL wrap pc from ROM_DEPTH-1 to 0 on increment; no fault is raised.
REQ-020 SHALL give a data instruction a latency of 3 cycles from FETCH entry to the reg_ena strobe when hold=0; throughput is one instruction per 3 cycles.
REQ-021 SHALL ignore run in every state except IDLE and HALTED.
REQ-022 SHALL transition HALTED->FETCH when run=1, with pc=0.
REQ-023 SHALL never assert reg_ena for two consecutive cycles.

Reset
REQ-024 SHALL, on reset=1 at any time including mid-ISSUE, immediately force state=IDLE, pc=0, reg_opcode=3'b111 (NOP), reg_data=0, reg_ena=0, halted=0, and instruction register=0.
REQ-025 SHALL leave ROM contents unaffected by reset.

Configuration
REQ-026 SHALL, when macro FETCH_PROG_LOAD_EN is defined, add input ports prog_we (1 bit), prog_addr (log2(ROM_DEPTH) bits), and prog_data (IW bits).
REQ-027 SHALL, with FETCH_PROG_LOAD_EN defined, perform a write on a clock edge when prog_we=1 && ena=1, only in IDLE or HALTED; writes in other states are dropped.
REQ-028 SHALL, when FETCH_PROG_LOAD_EN is undefined, omit the program-load ports and hold the ROM as a constant default image.

Structure
REQ-029 SHALL place the following in shared package fetch_pkg:
- state encoding;
- instruction field positions;
- ctrl op constants JMP=000 and HALT=001;
- register-file opcode constants LOAD0..OUT1 and NOP=111;
- the default ROM image.
REQ-030 SHALL use default ROM image: 0: LOAD0 0x5A; 1: MOV R1<-R0; 2: OUT R1; 3: HALT; all remaining words HALT.
REQ-031 SHALL implement storage in one sub-module, fetch_rom, with a synchronous read and the optional write port.

Verification
REQ-032 SHALL cover: default image, run pulse -> reg_ena strobes with (000,0x5A), (010,xx), (101,xx) at 3-cycle spacing, then halted=1 and pc=3.
REQ-033 SHALL cover: hold=1 for 5 cycles during the first ISSUE -> reg_ena low for those 5 cycles, then a single strobe with (000,0x5A).
REQ-034 SHALL cover: JMP at address 15 to 2 -> pc sequence ...,15,2, with no reg_ena strobe issued for the JMP.
REQ-035 SHALL cover: ROM filled with LOAD0 imm=addr, no HALT -> pc wraps 15->0 and reg_data follows 0x0F, 0x00.
REQ-036 SHALL cover: reset asserted mid-ISSUE -> all outputs at reset values immediately, with no strobe after release until run=1.
REQ-037 SHALL cover, with FETCH_PROG_LOAD_EN defined: write at address 0 while running is dropped; write at address 0 while HALTED followed by run -> the new instruction is issued.
